// File: rtl/divisor_pkg.sv
// Shared types and widths for the keypad operand-entry path into the divider.
package divisor_pkg;

  localparam int unsigned OPW  = 8;
  localparam int unsigned NIBW = 4;

  typedef enum logic [2:0] {
    A_HI,
    A_LO,
    B_HI,
    B_LO,
    LAUNCH,
    WAIT_DONE,
    SHOW
  } entry_state_t;

  typedef enum logic [1:0] {
    PH_A    = 2'd0,
    PH_B    = 2'd1,
    PH_DIV  = 2'd2,
    PH_SHOW = 2'd3
  } phase_t;

  // Display phase reported for each entry state.
  function automatic phase_t phase_of(input entry_state_t s);
    case (s)
      A_HI, A_LO:        phase_of = PH_A;
      B_HI, B_LO:        phase_of = PH_B;
      LAUNCH, WAIT_DONE: phase_of = PH_DIV;
      default:           phase_of = PH_SHOW;
    endcase
  endfunction

endpackage

// File: rtl/inactivity_timer.sv
// Down-counter that flags CYCLES enabled cycles since the last clr.
// expire is high for the cycle in which the terminal count is reached.
module inactivity_timer #(
  parameter int unsigned CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = $clog2(CYCLES);
  localparam logic [CW-1:0] LOAD = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          expire_q, expire_d;

  always_comb begin
    cnt_d    = cnt_q;
    expire_d = 1'b0;
    if (clr) begin
      cnt_d = LOAD;
    end else if (en && (cnt_q != '0)) begin
      cnt_d    = cnt_q - CW'(1);
      expire_d = (cnt_q == CW'(1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign expire = expire_q;

endmodule

// File: rtl/keypad_operand_entry.sv
// Assembles dividend and divisor from hex key events, launches the divider,
// and holds the operands until the divider reports done.
module keypad_operand_entry
  import divisor_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [NIBW-1:0]   key_code,
  input  logic              div_done,
  output logic [OPW-1:0]    a_bin,
  output logic [OPW-1:0]    b_bin,
  output logic              div_start,
  output logic [1:0]        phase,
  output logic [2*OPW-1:0]  disp_word,
  output logic              err_div0
);

  entry_state_t state_q, state_d;
  logic [OPW-1:0] a_q, a_d, b_q, b_d;
  logic           err_q, err_d;
  logic           start_q, start_d;
  phase_t         phase_q, phase_d;
  logic           tmo_clr, tmo_en, tmo_expire;

  inactivity_timer #(.CYCLES(TIMEOUT_CYC)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  // Next-state and operand update; a key always beats a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    tmo_clr = 1'b0;
    tmo_en  = (state_q == A_LO) || (state_q == B_HI) || (state_q == B_LO);

    case (state_q)
      A_HI, SHOW: begin
        if (key_valid) begin
          a_d     = {key_code, {NIBW{1'b0}}};
          b_d     = '0;
          err_d   = 1'b0;
          tmo_clr = 1'b1;
          state_d = A_LO;
        end
      end
      A_LO, B_HI: begin
        if (key_valid) begin
          err_d   = 1'b0;
          tmo_clr = 1'b1;
          if (state_q == A_LO) begin
            a_d[NIBW-1:0] = key_code;
            state_d       = B_HI;
          end else begin
            b_d     = {key_code, {NIBW{1'b0}}};
            state_d = B_LO;
          end
        end else if (tmo_expire) begin
          a_d     = '0;
          b_d     = '0;
          err_d   = 1'b0;
          tmo_clr = 1'b1;
          state_d = A_HI;
        end
      end
      B_LO: begin
        if (key_valid) begin
          tmo_clr = 1'b1;
          if ({b_q[OPW-1:NIBW], key_code} == '0) begin
            err_d   = 1'b1;
            b_d     = '0;
            state_d = B_HI;
          end else begin
            b_d[NIBW-1:0] = key_code;
            err_d         = 1'b0;
            state_d       = LAUNCH;
          end
        end else if (tmo_expire) begin
          b_d     = '0;
          tmo_clr = 1'b1;
          state_d = B_HI;
        end
      end
      LAUNCH:    state_d = WAIT_DONE;
      WAIT_DONE: if (div_done) state_d = SHOW;
      default:   state_d = A_HI;
    endcase

    start_d = (state_q == LAUNCH);
    phase_d = phase_of(state_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= A_HI;
      a_q     <= '0;
      b_q     <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      phase_q <= PH_A;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      start_q <= start_d;
      phase_q <= phase_d;
    end
  end

  assign a_bin     = a_q;
  assign b_bin     = b_q;
  assign err_div0  = err_q;
  assign div_start = start_q;
  assign phase     = phase_q;
  assign disp_word = {a_q, b_q};

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Bench for keypad_operand_entry: directed scenarios plus random key traffic
// checked against a digit-list reference model.
module tb_keypad_operand_entry;

  localparam int T = 100;
  localparam int M_ENTER = 0;
  localparam int M_DIV   = 1;
  localparam int M_SHOW  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        div_done;
  logic [7:0]  a_bin, b_bin;
  logic        div_start;
  logic [1:0]  phase;
  logic [15:0] disp_word;
  logic        err_div0;

  int n_tests = 0;
  int n_fail  = 0;
  int n_start = 0;

  // Reference model: nibbles entered so far plus a coarse mode.
  logic [3:0] m_dig[$];
  int         m_mode;
  int         m_idle;
  int         m_div_edges;
  logic       m_err;
  logic       m_start;

  keypad_operand_entry #(.TIMEOUT_CYC(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .div_done  (div_done),
    .a_bin     (a_bin),
    .b_bin     (b_bin),
    .div_start (div_start),
    .phase     (phase),
    .disp_word (disp_word),
    .err_div0  (err_div0)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (div_start === 1'b1) n_start++;

  task automatic model_reset();
    m_dig.delete();
    m_mode = M_ENTER;
    m_idle = 0;
    m_div_edges = 0;
    m_err = 1'b0;
    m_start = 1'b0;
  endtask

  task automatic model_step(input logic kv, input logic [3:0] kc, input logic dn);
    m_start = 1'b0;
    case (m_mode)
      M_ENTER: begin
        if (kv) begin
          m_err = 1'b0;
          m_idle = 0;
          m_dig.push_back(kc);
          if (m_dig.size() == 4) begin
            if (m_dig[2] == 4'h0 && m_dig[3] == 4'h0) begin
              m_err = 1'b1;
              void'(m_dig.pop_back());
              void'(m_dig.pop_back());
            end else begin
              m_mode = M_DIV;
              m_div_edges = 0;
            end
          end
        end else if (m_dig.size() > 0) begin
          m_idle++;
          if (m_idle == T) begin
            m_idle = 0;
            if (m_dig.size() == 3) void'(m_dig.pop_back());
            else begin
              m_dig.delete();
              m_err = 1'b0;
            end
          end
        end
      end
      M_DIV: begin
        if (m_div_edges == 0) m_start = 1'b1;
        else if (dn) m_mode = M_SHOW;
        m_div_edges++;
      end
      default: begin
        if (kv) begin
          m_dig.delete();
          m_dig.push_back(kc);
          m_err = 1'b0;
          m_idle = 0;
          m_mode = M_ENTER;
        end
      end
    endcase
  endtask

  function automatic logic [7:0] exp_a();
    logic [7:0] v = 8'h00;
    if (m_dig.size() >= 1) v[7:4] = m_dig[0];
    if (m_dig.size() >= 2) v[3:0] = m_dig[1];
    return v;
  endfunction

  function automatic logic [7:0] exp_b();
    logic [7:0] v = 8'h00;
    if (m_dig.size() >= 3) v[7:4] = m_dig[2];
    if (m_dig.size() >= 4) v[3:0] = m_dig[3];
    return v;
  endfunction

  function automatic logic [1:0] exp_phase();
    if (m_mode == M_DIV)  return 2'd2;
    if (m_mode == M_SHOW) return 2'd3;
    return (m_dig.size() >= 2) ? 2'd1 : 2'd0;
  endfunction

  task automatic tick();
    model_step(key_valid, key_code, div_done);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_code  = 4'($urandom);
  endtask

  task automatic press(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    key_valid = 1'b0;
    key_code = 4'h0;
    div_done = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({a_bin, b_bin, div_start, phase, disp_word, err_div0} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected 0", {a_bin, b_bin, div_start, phase, disp_word, err_div0});
    end
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int s0;
    press(4'h4); idle(39);
    press(4'h5); idle(39);
    press(4'h0); idle(39);
    s0 = n_start;
    press(4'h7);
    n_tests++;
    if (a_bin !== 8'h45 || b_bin !== 8'h07 || phase !== 2'd2) begin
      n_fail++;
      $display("FAIL basic_operands: got a=%h b=%h ph=%0d expected a=45 b=07 ph=2", a_bin, b_bin, phase);
    end
    n_tests++;
    if (div_start !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_start_early: got %b expected 0", div_start);
    end
    tick();
    n_tests++;
    if (div_start !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_start_pulse: got %b expected 1", div_start);
    end
    idle(5);
    n_tests++;
    if (n_start - s0 != 1) begin
      n_fail++;
      $display("FAIL basic_start_count: got %0d expected 1", n_start - s0);
    end
    div_done = 1'b1;
    tick();
    div_done = 1'b0;
    n_tests++;
    if (phase !== 2'd3 || a_bin !== 8'h45 || b_bin !== 8'h07 || disp_word !== 16'h4507) begin
      n_fail++;
      $display("FAIL basic_show: got ph=%0d disp=%h expected ph=3 disp=4507", phase, disp_word);
    end
  endtask

  task automatic test_div0();
    int s0;
    s0 = n_start;
    press(4'h1); press(4'h2); press(4'h0); press(4'h0);
    idle(3);
    n_tests++;
    if (err_div0 !== 1'b1 || phase !== 2'd1 || a_bin !== 8'h12 || b_bin !== 8'h00 || n_start != s0) begin
      n_fail++;
      $display("FAIL div0_reject: got err=%b ph=%0d a=%h b=%h starts=%0d expected err=1 ph=1 a=12 b=00 starts=0",
               err_div0, phase, a_bin, b_bin, n_start - s0);
    end
    press(4'h0);
    n_tests++;
    if (err_div0 !== 1'b0) begin
      n_fail++;
      $display("FAIL div0_err_clear: got %b expected 0", err_div0);
    end
    press(4'h3);
    idle(3);
    n_tests++;
    if (b_bin !== 8'h03 || n_start - s0 != 1) begin
      n_fail++;
      $display("FAIL div0_retry: got b=%h starts=%0d expected b=03 starts=1", b_bin, n_start - s0);
    end
    div_done = 1'b1;
    tick();
    div_done = 1'b0;
  endtask

  task automatic test_wait_keys();
    int s0;
    s0 = n_start;
    press(4'h2); press(4'h4); press(4'h0); press(4'h6);
    press(4'hF); press(4'hF); press(4'hF);
    idle(2);
    n_tests++;
    if (a_bin !== 8'h24 || b_bin !== 8'h06 || phase !== 2'd2 || n_start - s0 != 1) begin
      n_fail++;
      $display("FAIL wait_ignore_keys: got a=%h b=%h ph=%0d starts=%0d expected a=24 b=06 ph=2 starts=1",
               a_bin, b_bin, phase, n_start - s0);
    end
    div_done = 1'b1;
    tick();
    div_done = 1'b0;
    press(4'h8);
    n_tests++;
    if (a_bin !== 8'h80 || b_bin !== 8'h00 || phase !== 2'd0) begin
      n_fail++;
      $display("FAIL show_new_entry: got a=%h b=%h ph=%0d expected a=80 b=00 ph=0", a_bin, b_bin, phase);
    end
  endtask

  task automatic test_timeout();
    idle(T);
    n_tests++;
    if (a_bin !== 8'h00 || phase !== 2'd0) begin
      n_fail++;
      $display("FAIL tmo_a_lo: got a=%h ph=%0d expected a=00 ph=0", a_bin, phase);
    end
    press(4'h9);
    idle(T - 1);
    n_tests++;
    if (a_bin !== 8'h90) begin
      n_fail++;
      $display("FAIL tmo_early: got a=%h expected 90", a_bin);
    end
    idle(1);
    n_tests++;
    if (a_bin !== 8'h00) begin
      n_fail++;
      $display("FAIL tmo_exact: got a=%h expected 00", a_bin);
    end
    press(4'h9);
    idle(T - 2);
    press(4'h5);
    n_tests++;
    if (a_bin !== 8'h95 || phase !== 2'd1) begin
      n_fail++;
      $display("FAIL tmo_key_99: got a=%h ph=%0d expected a=95 ph=1", a_bin, phase);
    end
    press(4'h3);
    idle(T);
    n_tests++;
    if (a_bin !== 8'h95 || b_bin !== 8'h00 || phase !== 2'd1) begin
      n_fail++;
      $display("FAIL tmo_b_lo: got a=%h b=%h ph=%0d expected a=95 b=00 ph=1", a_bin, b_bin, phase);
    end
    idle(T);
    n_tests++;
    if (a_bin !== 8'h00 || phase !== 2'd0) begin
      n_fail++;
      $display("FAIL tmo_b_hi: got a=%h ph=%0d expected a=00 ph=0", a_bin, phase);
    end
    press(4'h9);
    idle(T - 1);
    press(4'h5);
    n_tests++;
    if (a_bin !== 8'h95 || phase !== 2'd1) begin
      n_fail++;
      $display("FAIL tmo_key_wins: got a=%h ph=%0d expected a=95 ph=1", a_bin, phase);
    end
    idle(T);
  endtask

  task automatic test_async_reset();
    press(4'h1); press(4'h2); press(4'h3);
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if ({a_bin, b_bin, div_start, phase, disp_word, err_div0} !== 36'h0) begin
      n_fail++;
      $display("FAIL async_reset_entry: got %h expected 0", {a_bin, b_bin, div_start, phase, disp_word, err_div0});
    end
    #1 rst = 1'b1;
    model_reset();
    press(4'hA);
    n_tests++;
    if (a_bin !== 8'hA0 || phase !== 2'd0) begin
      n_fail++;
      $display("FAIL after_reset_key: got a=%h ph=%0d expected a=a0 ph=0", a_bin, phase);
    end
    press(4'hB); press(4'h4); press(4'h5);
    tick();
    n_tests++;
    if (div_start !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_start: got %b expected 1", div_start);
    end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if ({a_bin, b_bin, div_start, phase, err_div0} !== 20'h0) begin
      n_fail++;
      $display("FAIL async_reset_div: got start=%b a=%h b=%h expected all 0", div_start, a_bin, b_bin);
    end
    #1 rst = 1'b1;
    model_reset();
  endtask

  task automatic test_back_to_back();
    press(4'hA);
    press(4'hB);
    n_tests++;
    if (a_bin !== 8'hAB || phase !== 2'd1) begin
      n_fail++;
      $display("FAIL back_to_back: got a=%h ph=%0d expected a=ab ph=1", a_bin, phase);
    end
  endtask

  task automatic test_random();
    int idle_len;
    for (int burst = 0; burst < 40; burst++) begin
      idle_len = $urandom_range(0, 130);
      for (int c = 0; c < 60 + idle_len; c++) begin
        key_valid = (c < 60) && ($urandom_range(0, 2) == 0);
        key_code  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
        div_done  = ($urandom_range(0, 5) == 0);
        tick();
        n_tests++;
        if (a_bin !== exp_a() || b_bin !== exp_b() || disp_word !== {exp_a(), exp_b()}) begin
          n_fail++;
          $display("FAIL rand_operands: got disp=%h a=%h b=%h expected %h%h", disp_word, a_bin, b_bin, exp_a(), exp_b());
        end
        n_tests++;
        if (phase !== exp_phase() || err_div0 !== m_err || div_start !== m_start) begin
          n_fail++;
          $display("FAIL rand_ctrl: got ph=%0d err=%b start=%b expected ph=%0d err=%b start=%b",
                   phase, err_div0, div_start, exp_phase(), m_err, m_start);
        end
      end
    end
    div_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div0();
    test_wait_keys();
    test_timeout();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_operand_entry.md
# keypad_operand_entry

Operand-entry sequencer between the keypad scanner and the divider core. Takes single-cycle decoded hex key events, assembles two 8-bit operands (dividend A, then divisor B, each entered MSB nibble first), and issues a one-cycle start to the divider. It then holds the operands stable until the divider reports done. It also provides the 16-bit word that the seven-segment multiplexer shows during entry, and rejects a zero divisor.

## Interface
- `TIMEOUT_CYC`, default 50_000_000: idle cycles after which a half-entered operand is discarded (1 s at 50 MHz).
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: asynchronous, active-low reset.
- `key_valid` in 1: one-cycle pulse from the scanner; a debounced key was pressed.
- `key_code` in 4: hex value of the key. Valid only while `key_valid`=1.
- `div_done` in 1: divider result ready. Level or pulse; sampled only in WAIT_DONE.
- `a_bin` out 8: assembled dividend.
- `b_bin` out 8: assembled divisor.
- `div_start` out 1: one-cycle start pulse to the divider.
- `phase` out 2: 0 = entering A, 1 = entering B, 2 = dividing, 3 = showing result.
- `disp_word` out 16: digits for display as {a_bin, b_bin}; nibbles not yet entered read 0.
- `err_div0` out 1: set when a zero divisor is entered; cleared by the next accepted key.

## Operation
- Reset values: all outputs 0, state A_HI, timeout counter 0.
- States and transitions:
  - A_HI: on key, a_bin[7:4]=code, a_bin[3:0]=0, b_bin=0, err_div0=0, go to A_LO.
  - A_LO: on key, a_bin[3:0]=code, go to B_HI.
  - B_HI: on key, b_bin[7:4]=code, b_bin[3:0]=0, go to B_LO.
  - B_LO: on key, b_bin[3:0]=code.
    - If the full divisor {b_bin[7:4],code}==0: err_div0=1, b_bin=0, go to B_HI. A is kept; no start is issued.
    - Otherwise go to LAUNCH.
  - LAUNCH: div_start=1 for exactly this cycle, go to WAIT_DONE.
  - WAIT_DONE: keys are ignored. When div_done=1, go to SHOW.
  - SHOW: a key starts a new entry exactly as A_HI does, using that key as the new A MSB, and goes to A_LO.
- `phase` mapping: A_HI/A_LO = 0, B_HI/B_LO = 1, LAUNCH/WAIT_DONE = 2, SHOW = 3.
- Timeout:
  - The counter runs only in A_LO, B_HI and B_LO, and clears on every accepted key.
  - When it reaches TIMEOUT_CYC-1 in A_LO or B_HI, return to A_HI and clear a_bin, b_bin and err_div0.
  - In B_LO, timeout returns to B_HI, clears b_bin, and keeps A.
- `a_bin` and `b_bin` are held constant from LAUNCH until the next accepted key in SHOW.
- `key_code` is ignored when `key_valid`=0.

## Timing
- All outputs are registered. A key accepted at edge t is visible in `a_bin`/`b_bin`/`phase` after edge t.
- Key on B_LO at edge t: `div_start` is high for the cycle between edges t+1 and t+2. It never lasts more than one cycle.
- `div_done` is sampled from the first WAIT_DONE cycle onward. A done asserted during LAUNCH is ignored.
- Key and timeout expiry in the same cycle: the key wins. It is accepted and the counter clears.
- Back-to-back `key_valid` pulses on consecutive cycles are each accepted.
- Reset asserted mid-entry or mid-division: outputs clear asynchronously, and `div_start` drops immediately. The divider is reset by the same `rst`.
- Timeout counter width is $clog2(TIMEOUT_CYC). Its terminal count is exactly TIMEOUT_CYC cycles after the last accepted key.

## Structure
- Shared package `divisor_pkg`:
  - `entry_state_t` enum (A_HI, A_LO, B_HI, B_LO, LAUNCH, WAIT_DONE, SHOW).
  - `OPW=8` operand width and `NIBW=4`.
  - `phase_t` encodings.
- Sub-module `inactivity_timer`: parameterised down-counter with `clr`, `en` and a one-cycle `expire` pulse. The rest is a single FSM module.

## Test plan
- Keys 4,5,0,7 with 40-cycle spacing:
  - Required: a_bin=0x45, b_bin=0x07, exactly one div_start one cycle after the '7' is accepted, phase=2.
  - Then div_done=1: phase=3 and operands unchanged.
- Keys 1,2,0,0:
  - Required: err_div0=1, no div_start, phase=1, a_bin=0x12, b_bin=0x00.
  - Then keys 0,3: div_start fires and b_bin=0x03.
- TIMEOUT_CYC=100, key 9, then 100 idle cycles:
  - Required: back in A_HI with a_bin=0.
  - The same stimulus with a key at cycle 99 must be accepted (no timeout).
- During WAIT_DONE, press F,F:
  - Required: no change to a_bin/b_bin and no extra div_start.
  - After done, key 8 gives a_bin=0x80, b_bin=0, phase=0.
- Drop rst low asynchronously between the B_HI and B_LO keys:
  - Required: all outputs 0 immediately.
  - After release, the FSM accepts a fresh A_HI key.
- key_valid on two consecutive cycles with codes A, B:
  - Required: a_bin=0xAB, phase=1.
